sccb_master: RTL and testbench

Write-only SCCB (OmniVision camera serial control bus) master. It serialises a 24-bit word as a 3-phase write transmission: ID address, sub-address, then data. It drives SIO_C, SIO_D and SCCB_E, and sits between the camera-register configuration logic and the sensor pins. Transactions launch without a start strobe: one after reset release, and another whenever the input word changes.

---
 rtl/sccb_master.sv | 178 +++++++++++++++++
 tb/tb_sccb_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_master.sv
// Write-only SCCB master: sends I_DATA as ID / sub-address / data phases.
// A write launches after reset release and whenever I_DATA differs from the last word sent.
module sccb_master #(
  parameter int QTR = 16
) (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic [23:0] I_DATA,
  output logic        O_SCCB_E_N,
  output logic        O_SIO_C,
  inout  logic        IO_SIO_D
);

  localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QTR - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BIT   = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     qtr_q, qtr_d;
  logic [3:0]     bit_q, bit_d;
  logic [1:0]     phase_q, phase_d;
  logic [23:0]    shift_q, shift_d;
  logic [23:0]    last_q, last_d;
  logic           pend_q, pend_d;
  logic           sio_c_q, sio_c_d;
  logic           sio_d_q, sio_d_d;
  logic           sio_oe_q, sio_oe_d;
  logic           e_n_q, e_n_d;
  logic           tick;

  // State and output registers; reset leaves the bus idle with a launch pending.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      qtr_q    <= 2'd0;
      bit_q    <= 4'd0;
      phase_q  <= 2'd0;
      shift_q  <= 24'd0;
      last_q   <= 24'd0;
      pend_q   <= 1'b1;
      sio_c_q  <= 1'b1;
      sio_d_q  <= 1'b1;
      sio_oe_q <= 1'b1;
      e_n_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      sio_c_q  <= sio_c_d;
      sio_d_q  <= sio_d_d;
      sio_oe_q <= sio_oe_d;
      e_n_q    <= e_n_d;
    end
  end

  // Next-state: each quarter-counter wrap advances the quarter, bit slot, phase or state.
  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shift_d = shift_q;
    last_d  = last_q;
    pend_d  = pend_q;
    tick    = (cnt_q == CNT_LAST);
    if ((state_q == S_IDLE) || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (pend_q || (I_DATA != last_q)) begin
          state_d = S_START;
          shift_d = I_DATA;
          last_d  = I_DATA;
          pend_d  = 1'b0;
          qtr_d   = 2'd0;
          bit_d   = 4'd0;
          phase_d = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick && (qtr_q == 2'd1)) begin
          state_d = S_BIT;
          qtr_d   = 2'd0;
        end else if (tick) begin
          qtr_d = qtr_q + 2'd1;
        end else begin
          qtr_d = qtr_q;
        end
      end
      S_BIT: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          // The don't-care slot ends a phase without shifting: the next byte is already on top.
          if ((qtr_q == 2'd3) && (bit_q == 4'd8)) begin
            bit_d = 4'd0;
            if (phase_q == 2'd2) begin
              state_d = S_STOP;
              phase_d = 2'd0;
            end else begin
              phase_d = phase_q + 2'd1;
            end
          end else if (qtr_q == 2'd3) begin
            bit_d   = bit_q + 4'd1;
            shift_d = {shift_q[22:0], 1'b0};
          end else begin
            bit_d = bit_q;
          end
        end else begin
          qtr_d = qtr_q;
        end
      end
      S_STOP: begin
        if (tick && (qtr_q == 2'd2)) begin
          state_d = S_IDLE;
          qtr_d   = 2'd0;
        end else if (tick) begin
          qtr_d = qtr_q + 2'd1;
        end else begin
          qtr_d = qtr_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin levels for the current quarter; registered, so pins lag the state by one clock.
  always_comb begin
    sio_c_d  = 1'b1;
    sio_d_d  = 1'b1;
    sio_oe_d = 1'b1;
    e_n_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        e_n_d = 1'b1;
      end
      S_START: begin
        sio_d_d = (qtr_q == 2'd0);
      end
      S_BIT: begin
        sio_c_d  = qtr_q[1];
        sio_d_d  = shift_q[23];
        sio_oe_d = (bit_q != 4'd8);
      end
      S_STOP: begin
        sio_c_d = (qtr_q != 2'd0);
        sio_d_d = (qtr_q == 2'd2);
      end
      default: begin
        e_n_d = 1'b1;
      end
    endcase
  end

  assign O_SCCB_E_N = e_n_q;
  assign O_SIO_C    = sio_c_q;
  assign IO_SIO_D   = sio_oe_q ? sio_d_q : 1'bz;

endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: each SIO_D net is built twice (pullup / pulldown copies) so a
// released line is recognised as Z; waveforms are compared against a quarter-based model.
module tb_sccb_master;

  localparam int QA = 16;
  localparam int QB = 1;

  typedef struct {
    logic [23:0] word;
    string       bits;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [23:0] data_a, data_b;
  logic        c_a, c_a2, e_a, e_a2, c_b, c_b2, e_b, e_b2;
  wire         d_a_pu, d_a_pd, d_b_pu, d_b_pd;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1:0]  cap_c [0:2047];
  logic [1:0]  cap_d [0:2047];
  int          cap_len = 0;

  pullup   (d_a_pu);
  pulldown (d_a_pd);
  pullup   (d_b_pu);
  pulldown (d_b_pd);

  always #20 clk = ~clk;

  sccb_master #(.QTR(QA)) u_a_pu (.I_CLK(clk), .I_RST(rst_a), .I_DATA(data_a),
    .O_SCCB_E_N(e_a), .O_SIO_C(c_a), .IO_SIO_D(d_a_pu));
  sccb_master #(.QTR(QA)) u_a_pd (.I_CLK(clk), .I_RST(rst_a), .I_DATA(data_a),
    .O_SCCB_E_N(e_a2), .O_SIO_C(c_a2), .IO_SIO_D(d_a_pd));
  sccb_master #(.QTR(QB)) u_b_pu (.I_CLK(clk), .I_RST(rst_b), .I_DATA(data_b),
    .O_SCCB_E_N(e_b), .O_SIO_C(c_b), .IO_SIO_D(d_b_pu));
  sccb_master #(.QTR(QB)) u_b_pd (.I_CLK(clk), .I_RST(rst_b), .I_DATA(data_b),
    .O_SCCB_E_N(e_b2), .O_SIO_C(c_b2), .IO_SIO_D(d_b_pd));

  // Symbols: 0, 1, 2 = Z (pull copies disagree), 3 = copies inconsistent.
  task automatic sample(input int p, output logic [1:0] c, output logic [1:0] d, output logic en);
    logic pu, pd, c1, c2;
    if (p == 0) begin
      pu = d_a_pu; pd = d_a_pd; c1 = c_a; c2 = c_a2; en = e_a | e_a2;
    end else begin
      pu = d_b_pu; pd = d_b_pd; c1 = c_b; c2 = c_b2; en = e_b | e_b2;
    end
    c = (c1 === c2) ? {1'b0, c1} : 2'd3;
    d = (pu !== pd) ? 2'd2 : {1'b0, pu};
  endtask

  // Expected pins t clocks after E_N fell, from the quarter layout of a write.
  task automatic model(input logic [23:0] w, input int t, input int tq,
                       output logic [1:0] c, output logic [1:0] d);
    int q, k, s, b;
    logic [7:0] byte_v;
    q = t / tq;
    if (q < 2) begin
      c = 2'd1;
      d = (q == 0) ? 2'd1 : 2'd0;
    end else if (q < 110) begin
      k = (q - 2) / 4;
      s = (q - 2) % 4;
      b = k % 9;
      byte_v = 8'(w >> (8 * (2 - k / 9)));
      c = (s >= 2) ? 2'd1 : 2'd0;
      d = (b == 8) ? 2'd2 : {1'b0, byte_v[7 - b]};
    end else begin
      s = q - 110;
      c = (s != 0) ? 2'd1 : 2'd0;
      d = (s == 2) ? 2'd1 : 2'd0;
    end
  endtask

  function automatic string sym_str(input logic [1:0] v);
    case (v)
      2'd0: sym_str = "0";
      2'd1: sym_str = "1";
      2'd2: sym_str = "Z";
      default: sym_str = "?";
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wait_en_fall(input int p, input int max, output int n);
    logic [1:0] c, d;
    logic en;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      sample(p, c, d, en);
    end while (en == 1'b1 && n < max);
    if (en == 1'b1) n = -1;
  endtask

  // Records pins from the current (E_N low) clock until E_N rises.
  task automatic capture(input int p, input int tq);
    logic [1:0] c, d;
    logic en;
    cap_len = 0;
    sample(p, c, d, en);
    while (en == 1'b0 && cap_len < 113 * tq + 8) begin
      cap_c[cap_len] = c;
      cap_d[cap_len] = d;
      cap_len++;
      @(negedge clk);
      sample(p, c, d, en);
    end
  endtask

  task automatic check_wave(input string name, input logic [23:0] w, input int tq);
    logic [1:0] mc, md;
    int bad_at;
    bad_at = -1;
    check({name, "_len"}, cap_len, 113 * tq);
    for (int t = 0; t < cap_len; t++) begin
      model(w, t, tq, mc, md);
      if (bad_at < 0 && (mc !== cap_c[t] || md !== cap_d[t])) bad_at = t;
    end
    n_cmp++;
    if (bad_at >= 0) begin
      n_bad++;
      model(w, bad_at, tq, mc, md);
      $display("FAIL %s_wave: clock %0d got C=%s D=%s, required C=%s D=%s", name, bad_at,
               sym_str(cap_c[bad_at]), sym_str(cap_d[bad_at]), sym_str(mc), sym_str(md));
    end
  endtask

  task automatic check_bits(input string name, input string exp, input int tq);
    string got;
    int t;
    logic [1:0] dv;
    got = "";
    for (int k = 0; k < 27; k++) begin
      t = (4 + 4 * k) * tq;
      dv = (t < cap_len) ? cap_d[t] : 2'd3;
      got = {got, sym_str(dv)};
    end
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %s, required %s", name, got, exp);
    end
  endtask

  task automatic check_proto(input string name, input int tq);
    int bad_st, bad_z, q;
    bad_st = 0;
    bad_z  = 0;
    for (int t = 1; t < cap_len; t++) begin
      if (cap_c[t] == 2'd1 && cap_c[t-1] == 2'd1 && cap_d[t] != cap_d[t-1] &&
          t != tq && t != 112 * tq) bad_st++;
    end
    for (int t = 0; t < cap_len; t++) begin
      q = t / tq;
      if (cap_d[t] == 2'd2 && !(q >= 2 && q < 110 && ((q - 2) / 4) % 9 == 8)) bad_z++;
    end
    check({name, "_stable"}, bad_st, 0);
    check({name, "_zonly"}, bad_z, 0);
  endtask

  initial begin
    vec_t tbl [4];
    logic [1:0] c, d;
    logic en;
    int n, fall_at, act;
    logic [23:0] w;

    tbl[0] = '{word: 24'hABCDEF, bits: "10101011Z11001101Z11101111Z"};
    tbl[1] = '{word: 24'h421280, bits: "01000010Z00010010Z10000000Z"};
    tbl[2] = '{word: 24'h42A55A, bits: "01000010Z10100101Z01011010Z"};
    tbl[3] = '{word: 24'h000000, bits: "00000000Z00000000Z00000000Z"};

    rst_a = 1'b1; rst_b = 1'b1;
    data_a = 24'hABCDEF; data_b = 24'h000000;
    repeat (4) @(negedge clk);
    sample(0, c, d, en);
    check("reset_state", {c, d, en}, {2'd1, 2'd1, 1'b1});
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Auto-launch after reset, with a data change landing mid-write.
    wait_en_fall(0, 10, n);
    check("launch_lat", n, 2);
    fork
      capture(0, QA);
      begin
        repeat (600) @(negedge clk);
        data_a = 24'h421280;
      end
    join
    check_wave("first", 24'hABCDEF, QA);
    check_bits("first_bits", tbl[0].bits, QA);
    fall_at = -1;
    for (int t = 0; t < cap_len; t++) begin
      if (fall_at < 0 && cap_d[t] == 2'd0) fall_at = t;
    end
    check("d_fall_after_en", fall_at, QA);

    wait_en_fall(0, 10, n);
    check("b2b_gap", n, 1);
    capture(0, QA);
    check_wave("second", 24'h421280, QA);
    check_bits("second_bits", tbl[1].bits, QA);

    act = 0;
    repeat (5000) begin
      @(negedge clk);
      sample(0, c, d, en);
      if (en == 1'b0 || c != 2'd1) act++;
    end
    check("idle_hold", act, 0);

    // Reset during phase 2, then a full resend.
    @(negedge clk);
    data_a = 24'h5A3C96;
    wait_en_fall(0, 10, n);
    check("third_lat", n, 2);
    repeat (1250) @(negedge clk);
    #5 rst_a = 1'b1;
    #1 sample(0, c, d, en);
    check("rst_async", {c, d, en}, {2'd1, 2'd1, 1'b1});
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    wait_en_fall(0, 10, n);
    check("rst_relaunch_lat", n, 2);
    capture(0, QA);
    check_wave("resend", 24'h5A3C96, QA);

    // Fast bus: table of fixed words.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (data_b == tbl[i].word) data_b = ~tbl[i].word;
      else data_b = tbl[i].word;
      if (data_b != tbl[i].word) begin
        wait_en_fall(1, 10, n);
        capture(1, QB);
        @(negedge clk);
        data_b = tbl[i].word;
      end
      wait_en_fall(1, 10, n);
      check($sformatf("tbl%0d_lat", i), n, 2);
      capture(1, QB);
      check_bits($sformatf("tbl%0d_bits", i), tbl[i].bits, QB);
      check_wave($sformatf("tbl%0d", i), tbl[i].word, QB);
    end

    // Fast bus: random words against the model and protocol rules.
    for (int i = 0; i < 20; i++) begin
      w = 24'($urandom);
      if (w == data_b) w = w ^ 24'h000001;
      @(negedge clk);
      data_b = w;
      wait_en_fall(1, 10, n);
      check($sformatf("rnd%0d_lat", i), n, 2);
      capture(1, QB);
      check_wave($sformatf("rnd%0d", i), w, QB);
      check_proto($sformatf("rnd%0d", i), QB);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
